// File: rtl/button_event_decoder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// button_event_decoder
//
// Turns one raw, asynchronous pushbutton into clean single-cycle events for
// the clock's time-setting logic: press, release, long-press and auto-repeat.
// The input is synchronized through two flops, then debounced by requiring
// DEBOUNCE_CYCLES consecutive disagreeing samples before the level flips.
// A three-state FSM (IDLE / PRESSED / HELD) times the hold from the debounced
// level only, so short bounces never disturb long/repeat cadence.
//
// Ports:
//   clk           in   system clock, all state on rising edge
//   rst           in   asynchronous active-high reset
//   btn_raw       in   raw pushbutton, asynchronous to clk, active high
//   btn_level     out  debounced, registered button level
//   press_pulse   out  one cycle when btn_level rises
//   release_pulse out  one cycle when btn_level falls
//   long_pulse    out  one cycle LONG_CYCLES after the press while held
//   repeat_pulse  out  one cycle every REPEAT_CYCLES after long_pulse
// ---------------------------------------------------------------------------
module button_event_decoder #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

    // Counters compare against "last value before the target" so the event
    // fires on the very edge where the count would reach the target.
    localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE      = DB_W'(1);
    localparam logic [HOLD_W-1:0] LONG_LAST   = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic              s1_reg, s2_reg;
    logic              level_reg, level_next;
    logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    state_t            state_reg, state_next;
    logic              press_reg, press_next;
    logic              release_reg, release_next;
    logic              long_reg, long_next;
    logic              repeat_reg, repeat_next;

    logic differ;
    logic flip;
    logic level_rise;
    logic level_fall;

    // Debouncer: the level flips on the edge where the disagreement count
    // would reach DEBOUNCE_CYCLES; rise/fall are the same-edge flip events.
    always_comb begin
        differ      = (s2_reg != level_reg);
        flip        = differ && (db_cnt_reg == DB_LAST);
        level_rise  = flip && s2_reg;
        level_fall  = flip && !s2_reg;
        level_next  = flip ? s2_reg : level_reg;
        db_cnt_next = (!differ || flip) ? '0 : (db_cnt_reg + DB_ONE);
    end

    // Event FSM. A release on the same edge as a due long/repeat wins and
    // the due event is dropped, which keeps the pulses mutually exclusive.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        press_next    = 1'b0;
        release_next  = 1'b0;
        long_next     = 1'b0;
        repeat_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                hold_cnt_next = '0;
                if (level_rise) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                end
            end
            PRESSED: begin
                if (level_fall) begin
                    state_next    = IDLE;
                    release_next  = 1'b1;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg == LONG_LAST) begin
                    state_next    = HELD;
                    long_next     = 1'b1;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_ONE;
                end
            end
            HELD: begin
                if (level_fall) begin
                    state_next    = IDLE;
                    release_next  = 1'b1;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg == REPEAT_LAST) begin
                    repeat_next   = 1'b1;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_ONE;
                end
            end
            default: begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg       <= 1'b0;
            s2_reg       <= 1'b0;
            level_reg    <= 1'b0;
            db_cnt_reg   <= '0;
            hold_cnt_reg <= '0;
            state_reg    <= IDLE;
            press_reg    <= 1'b0;
            release_reg  <= 1'b0;
            long_reg     <= 1'b0;
            repeat_reg   <= 1'b0;
        end else begin
            s1_reg       <= btn_raw;
            s2_reg       <= s1_reg;
            level_reg    <= level_next;
            db_cnt_reg   <= db_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            state_reg    <= state_next;
            press_reg    <= press_next;
            release_reg  <= release_next;
            long_reg     <= long_next;
            repeat_reg   <= repeat_next;
        end
    end

    assign btn_level     = level_reg;
    assign press_pulse   = press_reg;
    assign release_pulse = release_reg;
    assign long_pulse    = long_reg;
    assign repeat_pulse  = repeat_reg;

endmodule

// File: tb/tb_button_event_decoder.sv
`timescale 1ns/1ps
module tb_button_event_decoder;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;
    localparam int K_REPEAT  = 3;

    typedef struct {
        int rel;
        int kind;
    } ev_t;

    logic clk;
    logic rst;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int base = 0;
    int multi_hot = 0;
    bit mon_en = 0;
    int hot_n;

    ev_t exp_q[$];
    ev_t obs_q[$];

    button_event_decoder #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(16),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic ev_t mk(input int rel, input int kind);
        ev_t e;
        e.rel  = rel;
        e.kind = kind;
        return e;
    endfunction

    // Observed-event monitor: outputs after edge n are sampled on the
    // following falling edge and tagged with the test-relative edge number.
    always @(negedge clk) begin
        if (mon_en) begin
            hot_n = int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(repeat_pulse);
            if (hot_n > 1) multi_hot = multi_hot + 1;
            if (press_pulse)   obs_q.push_back(mk(edge_cnt - base, K_PRESS));
            if (release_pulse) obs_q.push_back(mk(edge_cnt - base, K_RELEASE));
            if (long_pulse)    obs_q.push_back(mk(edge_cnt - base, K_LONG));
            if (repeat_pulse)  obs_q.push_back(mk(edge_cnt - base, K_REPEAT));
        end
    end

    task automatic start_test();
        @(negedge clk);
        base = edge_cnt;
        exp_q.delete();
        obs_q.delete();
        multi_hot = 0;
        mon_en = 1;
    endtask

    // Return on the falling edge after relative edge `rel`.
    task automatic run_to(input int rel);
        while (edge_cnt - base < rel) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_raw = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (btn_level !== 1'b0) begin fails++; $display("FAIL reset_level: got %b want 0", btn_level); end
        tests++; if (press_pulse !== 1'b0) begin fails++; $display("FAIL reset_press: got %b want 0", press_pulse); end
        tests++; if (release_pulse !== 1'b0) begin fails++; $display("FAIL reset_release: got %b want 0", release_pulse); end
        tests++; if (long_pulse !== 1'b0) begin fails++; $display("FAIL reset_long: got %b want 0", long_pulse); end
        tests++; if (repeat_pulse !== 1'b0) begin fails++; $display("FAIL reset_repeat: got %b want 0", repeat_pulse); end
        $display("[TB] reset: outputs after reset %b%b%b%b%b", btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse);
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        ev_t e, o;
        start_test();
        run_to(9);  btn_raw = 1'b1;
        run_to(14);
        tests++; if (btn_level !== 1'b0) begin fails++; $display("FAIL clean_level_early: got %b want 0 at rel 14", btn_level); end
        run_to(15);
        tests++; if (btn_level !== 1'b1) begin fails++; $display("FAIL clean_level_on: got %b want 1 at rel 15", btn_level); end
        run_to(21); btn_raw = 1'b0;
        exp_q.push_back(mk(15, K_PRESS));
        exp_q.push_back(mk(27, K_RELEASE));
        run_to(40);
        tests++;
        if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL clean_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o.rel !== e.rel || o.kind !== e.kind) begin fails++; $display("FAIL clean_event: got kind %0d at %0d want kind %0d at %0d", o.kind, o.rel, e.kind, e.rel); end
            else $display("[TB] clean_press: kind %0d at rel %0d ok", o.kind, o.rel);
        end
        tests++; if (multi_hot !== 0) begin fails++; $display("FAIL clean_onehot: got %0d multi-pulse cycles want 0", multi_hot); end
        mon_en = 0;
    endtask

    task automatic test_bounce();
        start_test();
        for (int i = 0; i < 8; i++) begin
            run_to(9 + i);
            btn_raw = (i % 2 == 0);
        end
        run_to(19); btn_raw = 1'b1;
        run_to(22); btn_raw = 1'b0;
        run_to(25);
        tests++; if (btn_level !== 1'b0) begin fails++; $display("FAIL bounce_level_glitch: got %b want 0", btn_level); end
        run_to(40);
        tests++; if (btn_level !== 1'b0) begin fails++; $display("FAIL bounce_level_end: got %b want 0", btn_level); end
        tests++; if (obs_q.size() !== 0) begin fails++; $display("FAIL bounce_count: got %0d events want 0", obs_q.size()); end
        $display("[TB] bounce: %0d events, level %b", obs_q.size(), btn_level);
        mon_en = 0;
    endtask

    task automatic test_long_repeat();
        ev_t e, o;
        start_test();
        run_to(9);  btn_raw = 1'b1;
        run_to(69); btn_raw = 1'b0;
        exp_q.push_back(mk(15, K_PRESS));
        exp_q.push_back(mk(31, K_LONG));
        for (int n = 1; n <= 5; n++) exp_q.push_back(mk(31 + 8 * n, K_REPEAT));
        exp_q.push_back(mk(75, K_RELEASE));
        run_to(74);
        tests++; if (btn_level !== 1'b1) begin fails++; $display("FAIL long_level_held: got %b want 1 at rel 74", btn_level); end
        run_to(75);
        tests++; if (btn_level !== 1'b0) begin fails++; $display("FAIL long_level_fall: got %b want 0 at rel 75", btn_level); end
        run_to(100);
        tests++;
        if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL long_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o.rel !== e.rel || o.kind !== e.kind) begin fails++; $display("FAIL long_event: got kind %0d at %0d want kind %0d at %0d", o.kind, o.rel, e.kind, e.rel); end
            else $display("[TB] long_repeat: kind %0d at rel %0d ok", o.kind, o.rel);
        end
        tests++; if (multi_hot !== 0) begin fails++; $display("FAIL long_onehot: got %0d multi-pulse cycles want 0", multi_hot); end
        mon_en = 0;
    endtask

    task automatic test_release_collide();
        ev_t e, o;
        start_test();
        run_to(9);  btn_raw = 1'b1;
        run_to(33); btn_raw = 1'b0;
        exp_q.push_back(mk(15, K_PRESS));
        exp_q.push_back(mk(31, K_LONG));
        exp_q.push_back(mk(39, K_RELEASE));
        run_to(39);
        tests++; if (release_pulse !== 1'b1) begin fails++; $display("FAIL collide_release: got %b want 1 at rel 39", release_pulse); end
        tests++; if (repeat_pulse !== 1'b0) begin fails++; $display("FAIL collide_repeat: got %b want 0 at rel 39", repeat_pulse); end
        run_to(70);
        tests++;
        if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL collide_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o.rel !== e.rel || o.kind !== e.kind) begin fails++; $display("FAIL collide_event: got kind %0d at %0d want kind %0d at %0d", o.kind, o.rel, e.kind, e.rel); end
            else $display("[TB] release_collide: kind %0d at rel %0d ok", o.kind, o.rel);
        end
        mon_en = 0;
    endtask

    task automatic test_mid_hold_bounce();
        ev_t e, o;
        start_test();
        run_to(9);  btn_raw = 1'b1;
        run_to(39); btn_raw = 1'b0;
        run_to(42); btn_raw = 1'b1;
        run_to(69); btn_raw = 1'b0;
        exp_q.push_back(mk(15, K_PRESS));
        exp_q.push_back(mk(31, K_LONG));
        for (int n = 1; n <= 5; n++) exp_q.push_back(mk(31 + 8 * n, K_REPEAT));
        exp_q.push_back(mk(75, K_RELEASE));
        run_to(45);
        tests++; if (btn_level !== 1'b1) begin fails++; $display("FAIL midbounce_level: got %b want 1 at rel 45", btn_level); end
        run_to(100);
        tests++;
        if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL midbounce_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o.rel !== e.rel || o.kind !== e.kind) begin fails++; $display("FAIL midbounce_event: got kind %0d at %0d want kind %0d at %0d", o.kind, o.rel, e.kind, e.rel); end
            else $display("[TB] mid_hold_bounce: kind %0d at rel %0d ok", o.kind, o.rel);
        end
        mon_en = 0;
    endtask

    task automatic test_reset_mid_hold();
        ev_t e, o;
        start_test();
        run_to(9);  btn_raw = 1'b1;
        exp_q.push_back(mk(15, K_PRESS));
        exp_q.push_back(mk(31, K_LONG));
        exp_q.push_back(mk(39, K_REPEAT));
        run_to(39);
        tests++; if ({btn_level, repeat_pulse} !== 2'b11) begin fails++; $display("FAIL rsthold_before: got level/repeat %b want 11", {btn_level, repeat_pulse}); end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse} !== 5'b0) begin
            fails++;
            $display("FAIL rsthold_async: got %b want 00000", {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse});
        end
        run_to(42); rst = 1'b0;
        // First post-reset sampling edge is 43, so the press lands on 48.
        exp_q.push_back(mk(48, K_PRESS));
        exp_q.push_back(mk(64, K_LONG));
        exp_q.push_back(mk(72, K_REPEAT));
        exp_q.push_back(mk(80, K_REPEAT));
        exp_q.push_back(mk(88, K_REPEAT));
        exp_q.push_back(mk(89, K_RELEASE));
        run_to(83); btn_raw = 1'b0;
        run_to(110);
        tests++;
        if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL rsthold_count: got %0d events want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
            if (o.rel !== e.rel || o.kind !== e.kind) begin fails++; $display("FAIL rsthold_event: got kind %0d at %0d want kind %0d at %0d", o.kind, o.rel, e.kind, e.rel); end
            else $display("[TB] reset_mid_hold: kind %0d at rel %0d ok", o.kind, o.rel);
        end
        tests++; if (multi_hot !== 0) begin fails++; $display("FAIL rsthold_onehot: got %0d multi-pulse cycles want 0", multi_hot); end
        mon_en = 0;
    endtask

    initial begin
        rst = 1'b1;
        btn_raw = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_release_collide();
        test_mid_hold_bounce();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
